frame_to_byte_tx_serializer: RTL and testbench
==============================================

FRAME_TO_BYTE_TX_SERIALIZER -- requirements
Module: frame_to_byte_tx_serializer

Interface
REQ-001 Parameter ADDR_W, default 12, address field width in bits.
REQ-002 Parameter DATA_W, default 8, data field width in bits; DATA_BYTES = ceil(DATA_W/8).
REQ-003 Parameter ADDR_BYTES, default 2, address bytes sent; ADDR_BYTES*8 < ADDR_W SHALL be an elaboration error.
REQ-004 Parameter FIFO_DEPTH, default 4, frame queue depth; must be a power of two >= 2.
REQ-005 Parameter CHECKSUM_EN, default 0, 1 appends an XOR checksum byte.
REQ-006 Parameter TIMEOUT_CYC, default 65535, per-byte UART handshake timeout in clk cycles.
REQ-007 clk  in  1  clock; all logic on rising edge.
REQ-008 rstn  in  1  reset, asynchronous, active-low.
REQ-009 frame_in  in  1+ADDR_W+DATA_W  {mode, addr, data}, mode at MSB.
REQ-010 frame_valid  in  1  frame offered.
REQ-011 frame_ready  out  1  high when the queue is not full.
REQ-012 uart_data_in  out  8  byte to the UART.
REQ-013 uart_wr_en  out  1  one-cycle write strobe to the UART.
REQ-014 uart_tx_busy  in  1  UART transmitting; synchronous to clk.
REQ-015 fifo_count  out  clog2(FIFO_DEPTH)+1  frames queued, excluding the frame in flight.
REQ-016 active  out  1  high while a frame is being serialized.
REQ-017 frame_done  out  1  one-cycle pulse after the last byte of a frame completes.
REQ-018 err_timeout  out  1  one-cycle pulse when a frame is aborted on timeout.

Function
REQ-019 A frame SHALL be accepted on any edge where frame_valid and frame_ready are both high, and written to the FIFO tail.
REQ-020 While the FIFO is full, frame_valid SHALL be ignored, with no flag and no overwrite.
REQ-021 Simultaneous push and pop SHALL leave fifo_count unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 Byte order per frame SHALL be:
- addr bytes, LSB first, zero-padded to ADDR_BYTES;
- data bytes, LSB first, zero-padded to DATA_BYTES;
- flags byte {7'b0, mode};
- if CHECKSUM_EN, the XOR of all preceding bytes of the frame.
REQ-023 The FSM SHALL have states IDLE, SEND, WAIT_START and WAIT_DONE, with state encoding wide enough for all states.
REQ-024 IDLE: when fifo_count > 0, pop the head into the shift buffer, clear the byte index and checksum, set active, and go to SEND on the next edge.
REQ-025 SEND: when uart_tx_busy is low, register uart_data_in, pulse uart_wr_en for exactly one cycle, clear the timeout counter, and go to WAIT_START.
REQ-026 WAIT_START: when uart_tx_busy is high, go to WAIT_DONE.
REQ-027 WAIT_DONE: on a falling edge of uart_tx_busy (previous cycle high, current cycle low):
- if bytes remain, increment the byte index and go to SEND;
- otherwise pulse frame_done, clear active and go to IDLE.
REQ-028 The timeout counter SHALL run in WAIT_START and WAIT_DONE; on reaching TIMEOUT_CYC, pulse err_timeout, drop the remaining bytes of the frame, clear active and go to IDLE, with no frame_done pulse.
REQ-029 Latency: with IDLE, an empty FIFO and uart_tx_busy low, uart_wr_en SHALL be high in the third cycle after the acceptance edge.
REQ-030 uart_data_in SHALL hold its value until the next uart_wr_en pulse.
REQ-031 The FIFO SHALL keep accepting frames while a frame is being serialized.

Reset
REQ-032 While rstn is low, the block SHALL hold:
- FSM in IDLE; FIFO empty; fifo_count 0;
- frame_ready 1; uart_data_in 8'h00;
- uart_wr_en, active, frame_done and err_timeout all 0.
REQ-033 Reset mid-frame SHALL discard the frame in flight and all queued frames, and the block SHALL not emit a uart_wr_en pulse in the first cycle after rstn deasserts.

Verification
REQ-034 Default parameters, frame {1, 12'hABC, 8'h5A}, UART model with busy held high for 10 cycles per byte -> bytes BC, 0A, 5A, 01, then one frame_done pulse.
REQ-035 CHECKSUM_EN=1, same frame -> bytes BC, 0A, 5A, 01, ED.
REQ-036 ADDR_W=20, ADDR_BYTES=3, DATA_W=16, frame {0, 20'h12345, 16'hBEEF} -> bytes 45, 23, 01, EF, BE, 00.
REQ-037 Default parameters, uart_tx_busy held high, 6 back-to-back frames -> 5 accepted, fifo_count=4, frame_ready low on the 6th, and all 5 frames are later sent in order.
REQ-038 TIMEOUT_CYC=16 and uart_tx_busy never rises -> err_timeout pulses 16 cycles after uart_wr_en with no frame_done, and the next queued frame starts in SEND.
REQ-039 rstn asserted during the 2nd byte with 2 frames queued -> all outputs at reset values, fifo_count=0, and no further uart_wr_en pulses.

Source files
------------

// File: rtl/frame_to_byte_tx_serializer.sv
// Frame-to-byte serializer: queues {mode, addr, data} frames and feeds them to a
// byte UART one byte at a time (addr LSB first, data LSB first, flags, optional
// XOR checksum), handshaking on uart_tx_busy with a per-byte timeout.
module frame_to_byte_tx_serializer #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 8,
    parameter int ADDR_BYTES  = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int CHECKSUM_EN = 0,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [ADDR_W+DATA_W:0]      frame_in,
    input  logic                        frame_valid,
    output logic                        frame_ready,
    output logic [7:0]                  uart_data_in,
    output logic                        uart_wr_en,
    input  logic                        uart_tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        active,
    output logic                        frame_done,
    output logic                        err_timeout
);

    localparam int  DATA_BYTES  = (DATA_W + 7) / 8;
    localparam int  FRAME_W     = 1 + ADDR_W + DATA_W;
    localparam int  PAY_BYTES   = ADDR_BYTES + DATA_BYTES + 1;
    localparam bit  CSUM_ON     = (CHECKSUM_EN != 0);
    localparam int  TOTAL_BYTES = PAY_BYTES + (CSUM_ON ? 1 : 0);
    localparam int  BUF_W       = PAY_BYTES * 8;
    localparam int  PTR_W       = $clog2(FIFO_DEPTH);
    localparam int  CNT_W       = PTR_W + 1;
    localparam int  IDX_W       = $clog2(TOTAL_BYTES + 1);
    localparam int  TO_W        = $clog2(TIMEOUT_CYC + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    generate
        if (ADDR_BYTES * 8 < ADDR_W) begin : g_addr_bytes_chk
            $error("ADDR_BYTES too small to carry ADDR_W address bits");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_chk
            $error("FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SEND, WAIT_START, WAIT_DONE} state_t;

    state_t                  state;
    logic [FRAME_W-1:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic                    push;
    logic                    pop;
    logic [FRAME_W-1:0]      head;
    logic [ADDR_BYTES*8-1:0] addr_pad;
    logic [DATA_BYTES*8-1:0] data_pad;
    logic [BUF_W-1:0]        head_buf;
    logic [BUF_W-1:0]        shbuf;
    logic [7:0]              csum;
    logic [7:0]              tx_byte;
    logic [IDX_W-1:0]        idx;
    logic [TO_W-1:0]         tcnt;
    logic                    busy_q;
    logic                    busy_fall;
    logic                    send_byte;
    logic                    more;
    logic                    next_byte;

    assign frame_ready = (fifo_count != FULL_CNT);
    assign push        = frame_valid && frame_ready;
    assign pop         = (state == IDLE) && (fifo_count != '0);
    assign busy_fall   = busy_q && !uart_tx_busy;
    assign send_byte   = (state == SEND) && !uart_tx_busy;
    assign more        = (idx != LAST_IDX);
    assign next_byte   = (state == WAIT_DONE) && busy_fall && more;
    assign tx_byte     = (CSUM_ON && (idx == LAST_IDX)) ? csum : shbuf[7:0];

    // Lay the head frame out as the byte stream: addr bytes, data bytes, flags.
    always_comb begin
        head                     = mem[rd_ptr];
        addr_pad                 = '0;
        addr_pad[ADDR_W-1:0]     = head[DATA_W +: ADDR_W];
        data_pad                 = '0;
        data_pad[DATA_W-1:0]     = head[DATA_W-1:0];
        head_buf                 = {7'b0, head[FRAME_W-1], data_pad, addr_pad};
    end

    // Frame storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= frame_in;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Shift buffer and running checksum of the frame in flight.
    always_ff @(posedge clk) begin
        if (pop) begin
            shbuf <= head_buf;
            csum  <= '0;
        end else begin
            if (send_byte) begin
                csum <= csum ^ tx_byte;
            end
            if (next_byte) begin
                shbuf <= shbuf >> 8;
            end
        end
    end

    // Byte handshake FSM with registered UART strobe, status pulses and timeout.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            idx          <= '0;
            tcnt         <= '0;
            busy_q       <= 1'b0;
            uart_data_in <= 8'h00;
            uart_wr_en   <= 1'b0;
            active       <= 1'b0;
            frame_done   <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            busy_q      <= uart_tx_busy;
            uart_wr_en  <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        idx    <= '0;
                        active <= 1'b1;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    if (!uart_tx_busy) begin
                        uart_data_in <= tx_byte;
                        uart_wr_en   <= 1'b1;
                        tcnt         <= '0;
                        state        <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    if (tcnt == TO_LAST) begin
                        err_timeout <= 1'b1;
                        active      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                        if (uart_tx_busy) begin
                            state <= WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (busy_fall) begin
                        if (more) begin
                            idx   <= idx + 1'b1;
                            state <= SEND;
                        end else begin
                            frame_done <= 1'b1;
                            active     <= 1'b0;
                            state      <= IDLE;
                        end
                    end else if (tcnt == TO_LAST) begin
                        err_timeout <= 1'b1;
                        active      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_to_byte_tx_serializer.sv
// Scoreboard bench for frame_to_byte_tx_serializer: three parameterisations,
// expected byte/event streams queued by the stimulus and checked by monitors.
module tb_frame_to_byte_tx_serializer;

    localparam int DONE = 'h100;
    localparam int ERR  = 'h200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   qa[$];
    int   qb[$];
    int   qc[$];

    // Instance A: defaults, short timeout
    logic [20:0] fi_a;
    logic        fv_a, fr_a, we_a, busy_a, act_a, fd_a, et_a;
    logic [7:0]  ud_a;
    logic [2:0]  cnt_a;
    bit          hold_a = 0;
    bit          mute_a = 0;
    int          uc_a = 0;

    // Instance B: checksum enabled
    logic [20:0] fi_b;
    logic        fv_b, fr_b, we_b, busy_b, act_b, fd_b, et_b;
    logic [7:0]  ud_b;
    logic [2:0]  cnt_b;
    int          uc_b = 0;

    // Instance C: wide address and data
    logic [36:0] fi_c;
    logic        fv_c, fr_c, we_c, busy_c, act_c, fd_c, et_c;
    logic [7:0]  ud_c;
    logic [2:0]  cnt_c;
    int          uc_c = 0;

    frame_to_byte_tx_serializer #(.TIMEOUT_CYC(16)) dut_a (
        .clk(clk), .rstn(rstn), .frame_in(fi_a), .frame_valid(fv_a), .frame_ready(fr_a),
        .uart_data_in(ud_a), .uart_wr_en(we_a), .uart_tx_busy(busy_a), .fifo_count(cnt_a),
        .active(act_a), .frame_done(fd_a), .err_timeout(et_a));

    frame_to_byte_tx_serializer #(.CHECKSUM_EN(1)) dut_b (
        .clk(clk), .rstn(rstn), .frame_in(fi_b), .frame_valid(fv_b), .frame_ready(fr_b),
        .uart_data_in(ud_b), .uart_wr_en(we_b), .uart_tx_busy(busy_b), .fifo_count(cnt_b),
        .active(act_b), .frame_done(fd_b), .err_timeout(et_b));

    frame_to_byte_tx_serializer #(.ADDR_W(20), .ADDR_BYTES(3), .DATA_W(16)) dut_c (
        .clk(clk), .rstn(rstn), .frame_in(fi_c), .frame_valid(fv_c), .frame_ready(fr_c),
        .uart_data_in(ud_c), .uart_wr_en(we_c), .uart_tx_busy(busy_c), .fifo_count(cnt_c),
        .active(act_c), .frame_done(fd_c), .err_timeout(et_c));

    // UART models: busy rises the cycle after a write strobe and stays high 10 cycles.
    always @(posedge clk) begin
        if (we_a) uc_a <= 10; else if (uc_a > 0) uc_a <= uc_a - 1;
        if (we_b) uc_b <= 10; else if (uc_b > 0) uc_b <= uc_b - 1;
        if (we_c) uc_c <= 10; else if (uc_c > 0) uc_c <= uc_c - 1;
    end
    assign busy_a = hold_a ? 1'b1 : (mute_a ? 1'b0 : (uc_a > 0));
    assign busy_b = (uc_b > 0);
    assign busy_c = (uc_c > 0);

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic score(input int which, input int tok);
        bit empty;
        int req;
        case (which)
            0:       empty = (qa.size() == 0);
            1:       empty = (qb.size() == 0);
            default: empty = (qc.size() == 0);
        endcase
        if (empty) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stream%0d: got %0h, expected no event", which, tok);
        end else begin
            case (which)
                0:       req = qa.pop_front();
                1:       req = qb.pop_front();
                default: req = qc.pop_front();
            endcase
            check($sformatf("stream%0d", which), tok, req);
        end
    endtask

    // Monitors: every strobe or status pulse consumes the next expected token.
    always @(negedge clk) begin
        if (we_a) score(0, int'(ud_a));
        if (fd_a) score(0, DONE);
        if (et_a) score(0, ERR);
        if (we_b) score(1, int'(ud_b));
        if (fd_b) score(1, DONE);
        if (et_b) score(1, ERR);
        if (we_c) score(2, int'(ud_c));
        if (fd_c) score(2, DONE);
        if (et_c) score(2, ERR);
    end

    function automatic logic [20:0] mk_a(input int k);
        logic [11:0] a;
        logic [7:0]  d;
        a = 12'h3C0 + 12'(k);
        d = 8'hA0 + 8'(k);
        return {1'(k & 1), a, d};
    endfunction

    function automatic void exp_a(input int k);
        qa.push_back('hC0 + k);
        qa.push_back('h03);
        qa.push_back('hA0 + k);
        qa.push_back(k & 1);
        qa.push_back(DONE);
    endfunction

    task automatic drain(input int which, input int maxc);
        int t;
        int sz;
        t = 0;
        sz = (which == 0) ? qa.size() : (which == 1) ? qb.size() : qc.size();
        while (sz != 0 && t < maxc) begin
            @(negedge clk);
            t++;
            sz = (which == 0) ? qa.size() : (which == 1) ? qb.size() : qc.size();
        end
        check($sformatf("drain%0d", which), sz, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int nwr;
        rstn = 1'b0;
        fv_a = 0; fv_b = 0; fv_c = 0;
        fi_a = '0; fi_b = '0; fi_c = '0;
        repeat (3) @(negedge clk);
        check("rst_count",  cnt_a, 0);
        check("rst_ready",  fr_a, 1);
        check("rst_data",   ud_a, 0);
        check("rst_wr",     we_a, 0);
        check("rst_active", act_a, 0);
        check("rst_done",   fd_a, 0);
        check("rst_err",    et_a, 0);
        check("rst_ready_c", fr_c, 1);
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_wr", we_a, 0);

        // Basic frame, with latency
        qa.push_back('hBC); qa.push_back('h0A); qa.push_back('h5A); qa.push_back('h01);
        qa.push_back(DONE);
        fi_a = {1'b1, 12'hABC, 8'h5A};
        fv_a = 1;
        @(negedge clk);
        fv_a = 0;
        check("lat_c1", we_a, 0);
        @(negedge clk);
        check("lat_c2", we_a, 0);
        check("lat_active", act_a, 1);
        @(negedge clk);
        check("lat_c3", we_a, 1);
        drain(0, 300);
        check("data_hold", ud_a, 'h01);
        check("idle_active", act_a, 0);

        // Checksum variant
        qb.push_back('hBC); qb.push_back('h0A); qb.push_back('h5A); qb.push_back('h01);
        qb.push_back('hED); qb.push_back(DONE);
        fi_b = {1'b1, 12'hABC, 8'h5A};
        fv_b = 1;
        @(negedge clk);
        fv_b = 0;
        drain(1, 300);

        // Wide address/data variant
        qc.push_back('h45); qc.push_back('h23); qc.push_back('h01);
        qc.push_back('hEF); qc.push_back('hBE); qc.push_back('h00); qc.push_back(DONE);
        fi_c = {1'b0, 20'h12345, 16'hBEEF};
        fv_c = 1;
        @(negedge clk);
        fv_c = 0;
        drain(2, 300);

        // Back-pressure: UART stuck busy, six frames offered back to back
        hold_a = 1;
        for (int k = 1; k <= 6; k++) begin
            fi_a = mk_a(k);
            fv_a = 1;
            if (k <= 5) exp_a(k);
            check($sformatf("ready_before_%0d", k), fr_a, (k == 6) ? 0 : 1);
            @(negedge clk);
        end
        fv_a = 0;
        check("full_count", cnt_a, 4);
        check("full_ready", fr_a, 0);
        nwr = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (we_a) nwr++;
        end
        check("hold_no_wr", nwr, 0);
        check("hold_count", cnt_a, 4);
        hold_a = 0;
        drain(0, 1500);
        check("empty_count", cnt_a, 0);

        // Timeout: UART never reports busy
        mute_a = 1;
        qa.push_back('hC7); qa.push_back(ERR); qa.push_back('hC8); qa.push_back(ERR);
        for (int k = 7; k <= 8; k++) begin
            fi_a = mk_a(k);
            fv_a = 1;
            @(negedge clk);
        end
        fv_a = 0;
        t = 0;
        while (!we_a && t < 50) begin @(negedge clk); t++; end
        check("to_wr_seen", we_a, 1);
        t = 0;
        do begin @(negedge clk); t++; end while (!et_a && t < 40);
        check("to_gap", t, 16);
        check("to_active", act_a, 0);
        t = 0;
        do begin @(negedge clk); t++; end while (!we_a && t < 40);
        check("to_next_send", t, 2);
        t = 0;
        do begin @(negedge clk); t++; end while (!et_a && t < 40);
        check("to_gap2", t, 16);
        mute_a = 0;
        drain(0, 20);
        repeat (15) @(negedge clk);

        // Reset mid-frame with two frames queued
        qa.push_back('hC9); qa.push_back('h03);
        for (int k = 9; k <= 11; k++) begin
            fi_a = mk_a(k);
            fv_a = 1;
            @(negedge clk);
        end
        fv_a = 0;
        check("queued2", cnt_a, 2);
        nwr = we_a ? 1 : 0;
        t = 0;
        while (nwr < 2 && t < 100) begin
            @(negedge clk);
            t++;
            if (we_a) nwr++;
        end
        check("two_bytes", nwr, 2);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("mid_rst_count",  cnt_a, 0);
        check("mid_rst_ready",  fr_a, 1);
        check("mid_rst_data",   ud_a, 0);
        check("mid_rst_wr",     we_a, 0);
        check("mid_rst_active", act_a, 0);
        check("mid_rst_done",   fd_a, 0);
        check("mid_rst_err",    et_a, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        nwr = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (we_a) nwr++;
        end
        check("post_rst_no_wr", nwr, 0);
        check("post_rst_count", cnt_a, 0);
        check("post_rst_active", act_a, 0);
        check("qa_left", qa.size(), 0);
        check("qb_left", qb.size(), 0);
        check("qc_left", qc.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
